// File: rtl/matriz_pkg.sv
// Shared types and helpers for the row line encoder.
// Maps a settled one-hot row vector (bit k-1 = Lk) back to the 3-bit ABC code 7-k;
// an all-zero vector maps to CODE_NONE (3'b111).
package matriz_pkg;

    typedef logic [6:0] row_vec_t;
    typedef logic [2:0] row_code_t;

    localparam row_code_t CODE_NONE = 3'b111;

    typedef enum logic {
        S_TRACK  = 1'b0,
        S_STABLE = 1'b1
    } deb_state_t;

    // Encode a zero or one-hot row vector; Lk -> 7-k, no row -> CODE_NONE.
    // Multi-hot vectors also fall into the default arm, but they are
    // filtered out by the caller before the code is used.
    function automatic row_code_t onehot_to_code(input row_vec_t v);
        row_code_t code;
        case (v)
            7'b0000001: code = 3'b110;
            7'b0000010: code = 3'b101;
            7'b0000100: code = 3'b100;
            7'b0001000: code = 3'b011;
            7'b0010000: code = 3'b010;
            7'b0100000: code = 3'b001;
            7'b1000000: code = 3'b000;
            default:    code = CODE_NONE;
        endcase
        return code;
    endfunction

    // True when two or more row lines are high at the same time.
    function automatic logic is_multi_hot(input row_vec_t v);
        return ((v & (v - 7'd1)) != 7'd0);
    endfunction

endpackage

// File: rtl/row_debouncer.sv
// Two-flop synchroniser plus debounce FSM for the 7 row lines.
// Emits the settled vector together with a one-cycle eval strobe each time
// the synced lines have been identical for DEBOUNCE_CYCLES consecutive samples.
module row_debouncer
    import matriz_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] l_in,
    output logic [6:0] settled,
    output logic       eval
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_CYCLES - 1);

    row_vec_t      sync1_q, sync1_d;
    row_vec_t      sync2_q, sync2_d;
    row_vec_t      prev_q, prev_d;
    row_vec_t      settled_q, settled_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_s;
    deb_state_t    state_q, state_d;
    logic          eval_q, eval_d;
    logic          change_s;

    // Next-state logic: synchroniser shift, change detection, saturating counter and FSM.
    always_comb begin
        sync1_d   = l_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        settled_d = settled_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        eval_d    = 1'b0;
        change_s  = (sync2_q != prev_q);
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CW'(1);
        end
        case (state_q)
            S_TRACK: begin
                if (change_s) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= CNT_TGT) begin
                        state_d   = S_STABLE;
                        eval_d    = 1'b1;
                        settled_d = sync2_q;
                    end else begin
                        state_d   = S_TRACK;
                    end
                end
            end
            S_STABLE: begin
                if (change_s) begin
                    state_d = S_TRACK;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_STABLE;
                end
            end
            default: begin
                state_d = S_TRACK;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 7'b0;
            sync2_q   <= 7'b0;
            prev_q    <= 7'b0;
            settled_q <= 7'b0;
            cnt_q     <= {CW{1'b0}};
            state_q   <= S_TRACK;
            eval_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            settled_q <= settled_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            eval_q    <= eval_d;
        end
    end

    assign settled = settled_q;
    assign eval    = eval_q;

endmodule

// File: rtl/row_line_encoder.sv
// Row line encoder: debounced 7-line row input encoded to the 3-bit ABC code
// and delivered once per change through a single-entry valid/ready buffer.
// err flags settled multi-hot patterns, ovf flags codes dropped on a full buffer.
// Optional feature macro: ROW_ENC_PARITY_EN adds out_par = ~^out_code.
module row_line_encoder
    import matriz_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] l_in,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
`ifdef ROW_ENC_PARITY_EN
    output logic       ovf,
    output logic       out_par
`else
    output logic       ovf
`endif
);

    row_vec_t  settled_s;
    logic      eval_s;
    row_code_t event_code_s;

    row_vec_t  last_acc_q, last_acc_d;
    row_code_t out_code_q, out_code_d;
    logic      out_valid_q, out_valid_d;
    logic      err_q, err_d;
    logic      ovf_q, ovf_d;
    logic      out_par_q, out_par_d;

    row_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .l_in    (l_in),
        .settled (settled_s),
        .eval    (eval_s)
    );

    // Classify the settled pattern and update the output buffer and pulse flags.
    always_comb begin
        last_acc_d   = last_acc_q;
        out_code_d   = out_code_q;
        err_d        = 1'b0;
        ovf_d        = 1'b0;
        event_code_s = onehot_to_code(settled_s);
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (eval_s) begin
            if (settled_s == last_acc_q) begin
                last_acc_d = last_acc_q;
            end else if (is_multi_hot(settled_s)) begin
                err_d = 1'b1;
            end else begin
                // last_acc tracks the pattern even if the code itself is dropped.
                last_acc_d = settled_s;
                if (out_valid_q && !out_ready) begin
                    ovf_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_code_d  = event_code_s;
                end
            end
        end else begin
            last_acc_d = last_acc_q;
        end
        out_par_d = ~^out_code_d;
    end

    // Output buffer and flag registers; async active-low reset drops any pending code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_acc_q  <= 7'b0;
            out_code_q  <= CODE_NONE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_par_q   <= 1'b0;
        end else begin
            last_acc_q  <= last_acc_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            out_par_q   <= out_par_d;
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign ovf       = ovf_q;
`ifdef ROW_ENC_PARITY_EN
    assign out_par   = out_par_q;
`else
    logic unused_par_s;
    assign unused_par_s = out_par_q;
`endif

endmodule
